rc_capture_scheduler: RTL and testbench

- Time-multiplexes one pulse-width measurement datapath across NCH RC receiver PWM inputs.
- Channels are serviced in round-robin order, 0 to NCH-1.
- Each high time is converted to a 0..1000 ratio with saturation, and invalid pulses are rejected.
- Detects loss of signal per channel and drives a global failsafe flag. Sits between the receiver pins and the flight-control mixer.

---
 rtl/rc_capture_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_rc_capture_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rc_capture_scheduler.sv
// rc_capture_scheduler: shares one pulse-width measurement datapath across NCH RC PWM
// inputs in round-robin order. Each high time becomes a 0..1000 ratio. A pulse outside
// the accepted window is ignored. A channel that shows no pulse within its slot time is
// flagged as lost, and any lost channel raises the global failsafe flag.
module rc_capture_scheduler #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned CLK_PER_US  = 50,
  parameter int unsigned MIN_US      = 1000,
  parameter int unsigned MAX_US      = 2000,
  parameter int unsigned VALID_LO_US = 800,
  parameter int unsigned VALID_HI_US = 2200,
  parameter int unsigned TIMEOUT_CYC = 2500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NCH-1:0]    pwm_in,
  output logic [13*NCH-1:0] ratio_bus,
  output logic [NCH-1:0]    lost,
  output logic              failsafe,
  output logic              frame_done,
  output logic [2:0]        active_ch
);

  localparam int unsigned PW         = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_US - 1);
  localparam logic [21:0] SLOT_LAST  = 22'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  CH_LAST    = 3'(NCH - 1);
  localparam logic [11:0] MIN_W      = 12'(MIN_US);
  localparam logic [11:0] MAX_W      = 12'(MAX_US);
  localparam logic [11:0] LO_W       = 12'(VALID_LO_US);
  localparam logic [11:0] HI_W       = 12'(VALID_HI_US);

  typedef enum logic [2:0] {
    StSyncLow,
    StWaitRise,
    StMeasure,
    StEval,
    StAdvance
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        ch_q, ch_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [11:0]       us_q, us_d;
  logic [21:0]       slot_q, slot_d;
  logic [13*NCH-1:0] ratio_q, ratio_d;
  logic [NCH-1:0]    lost_q, lost_d;
  logic [NCH-1:0]    frame_ok_q, frame_ok_d;
  logic              fs_q, fs_d;
  logic [NCH-1:0]    sync1_q, sync2_q;

  logic [NCH-1:0]    ch_oh;
  logic              s;
  logic              timeout;
  logic              ratio_we;
  logic [12:0]       ratio_new;
  logic              lost_set;
  logic              lost_clr;
  logic              ok_set;

  assign timeout = (slot_q == SLOT_LAST);

  // Decode the serviced channel and pick its synchronized PWM bit.
  always_comb begin
    ch_oh = '0;
    s     = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == 3'(k)) begin
        ch_oh[k] = 1'b1;
        s        = sync2_q[k];
      end
    end
  end

  // Next-state logic for the slot FSM, counters, results and failsafe.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    presc_d    = presc_q;
    us_d       = us_q;
    slot_d     = slot_q;
    ratio_d    = ratio_q;
    lost_d     = lost_q;
    frame_ok_d = frame_ok_q;
    fs_d       = fs_q;
    frame_done = 1'b0;
    ratio_we   = 1'b0;
    ratio_new  = '0;
    lost_set   = 1'b0;
    lost_clr   = 1'b0;
    ok_set     = 1'b0;

    if (|lost_q) fs_d = 1'b1;

    if (!enable) begin
      // Partial frame results are discarded so a restart cannot reuse them.
      state_d    = StSyncLow;
      ch_d       = '0;
      presc_d    = '0;
      us_d       = '0;
      slot_d     = '0;
      frame_ok_d = '0;
    end else begin
      unique case (state_q)
        StSyncLow: begin
          slot_d = slot_q + 22'd1;
          if (timeout) begin
            ratio_we = 1'b1;
            lost_set = 1'b1;
            state_d  = StAdvance;
          end else if (!s) begin
            state_d = StWaitRise;
          end
        end
        StWaitRise: begin
          slot_d = slot_q + 22'd1;
          if (timeout) begin
            ratio_we = 1'b1;
            lost_set = 1'b1;
            state_d  = StAdvance;
          end else if (s) begin
            presc_d = '0;
            us_d    = '0;
            state_d = StMeasure;
          end
        end
        StMeasure: begin
          slot_d = slot_q + 22'd1;
          // The falling-edge cycle is counted too, so a pulse of H cycles reads H/CLK_PER_US.
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (us_q != 12'hfff) us_d = us_q + 12'd1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
          if (!s) begin
            state_d = StEval;
          end else if (timeout) begin
            ratio_we = 1'b1;
            lost_set = 1'b1;
            state_d  = StAdvance;
          end
        end
        StEval: begin
          if (us_q >= LO_W && us_q <= HI_W) begin
            ratio_we = 1'b1;
            lost_clr = 1'b1;
            ok_set   = 1'b1;
            if (us_q < MIN_W) begin
              ratio_new = '0;
            end else if (us_q <= MAX_W) begin
              ratio_new = {1'b0, us_q - MIN_W};
            end else begin
              ratio_new = 13'd1000;
            end
          end
          state_d = StAdvance;
        end
        StAdvance: begin
          slot_d  = '0;
          state_d = StSyncLow;
          if (ch_q == CH_LAST) begin
            ch_d       = '0;
            frame_done = 1'b1;
            if ((&frame_ok_q) && !(|lost_q)) fs_d = 1'b0;
            frame_ok_d = '0;
          end else begin
            ch_d = ch_q + 3'd1;
          end
        end
        default: state_d = StSyncLow;
      endcase

      for (int k = 0; k < NCH; k++) begin
        if (ratio_we && ch_oh[k]) ratio_d[13*k +: 13] = ratio_new;
      end
      if (lost_set) lost_d = lost_q | ch_oh;
      if (lost_clr) lost_d = lost_q & ~ch_oh;
      if (ok_set)   frame_ok_d = frame_ok_q | ch_oh;
    end
  end

  // State, counters, results and input synchronizers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StSyncLow;
      ch_q       <= '0;
      presc_q    <= '0;
      us_q       <= '0;
      slot_q     <= '0;
      ratio_q    <= '0;
      lost_q     <= '1;
      frame_ok_q <= '0;
      fs_q       <= 1'b1;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      presc_q    <= presc_d;
      us_q       <= us_d;
      slot_q     <= slot_d;
      ratio_q    <= ratio_d;
      lost_q     <= lost_d;
      frame_ok_q <= frame_ok_d;
      fs_q       <= fs_d;
      sync1_q    <= pwm_in;
      sync2_q    <= sync1_q;
    end
  end

  assign ratio_bus = ratio_q;
  assign lost      = lost_q;
  assign failsafe  = fs_q;
  assign active_ch = ch_q;

endmodule

// File: tb/tb_rc_capture_scheduler.sv
// Bench for rc_capture_scheduler, run with a scaled clock (2 cycles per us) and a short slot
// timeout. Table rows drive one slot each; a scoreboard checks every slot as it ends.
module tb_rc_capture_scheduler;

  localparam int NCH = 4;
  localparam int TMO = 5000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b1;
  logic [NCH-1:0]    pwm = '0;
  logic [13*NCH-1:0] ratio_bus;
  logic [NCH-1:0]    lost;
  logic              failsafe;
  logic              frame_done;
  logic [2:0]        active_ch;

  rc_capture_scheduler #(
    .NCH         (NCH),
    .CLK_PER_US  (2),
    .MIN_US      (1000),
    .MAX_US      (2000),
    .VALID_LO_US (800),
    .VALID_HI_US (2200),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pwm_in     (pwm),
    .ratio_bus  (ratio_bus),
    .lost       (lost),
    .failsafe   (failsafe),
    .frame_done (frame_done),
    .active_ch  (active_ch)
  );

  always #5 clk = ~clk;

  // hi = 0 means the line stays low for the whole slot.
  typedef struct {
    int ch;
    int hi;
    int ratio;
    int lost;
    int fs;
  } row_t;

  row_t rows[$];
  row_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   fd_count = 0;
  bit   mon_en = 1'b0;
  logic [2:0] prev_ch = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: when the DUT moves off a channel, that slot's results must be final.
  always @(negedge clk) begin
    row_t e;
    if (frame_done) fd_count++;
    if (mon_en && !reset && active_ch != prev_ch) begin
      if (sbq.size() == 0) begin
        check("unexpected_slot_end", 64'(prev_ch), 64'd99);
      end else begin
        e = sbq.pop_front();
        check("slot_order", 64'(prev_ch), 64'(e.ch));
        check($sformatf("ch%0d_ratio", e.ch), 64'(ratio_bus[13*e.ch +: 13]), 64'(e.ratio));
        check($sformatf("ch%0d_lost", e.ch), 64'(lost[e.ch]), 64'(e.lost));
        check($sformatf("ch%0d_failsafe", e.ch), 64'(failsafe), 64'(e.fs));
      end
    end
    prev_ch = active_ch;
  end

  task automatic wait_ch(input int ch);
    int n = 0;
    while (active_ch != 3'(ch) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("wait_for_channel", 64'(active_ch), 64'(ch));
  endtask

  task automatic wait_leave(input int ch);
    int n = 0;
    while (active_ch == 3'(ch) && n < TMO + 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO + 3000) check("slot_never_ended", 64'(active_ch), 64'(ch + 1));
  endtask

  task automatic pulse(input int ch, input int hi);
    pwm[ch] = 1'b1;
    repeat (hi) @(negedge clk);
    pwm[ch] = 1'b0;
  endtask

  logic [13*NCH-1:0] hold_bus;

  initial begin
    // Frame 1: nominal values, failsafe drops at the first all-valid frame end.
    rows.push_back('{0, 3000,  500, 0, 1});
    rows.push_back('{1, 2000,    0, 0, 1});
    rows.push_back('{2, 4000, 1000, 0, 1});
    rows.push_back('{3, 3000,  500, 0, 0});
    // Frame 2: truncation of 1200.5 us, above-max and below-min saturation.
    rows.push_back('{0, 2401,  200, 0, 0});
    rows.push_back('{1, 4200, 1000, 0, 0});
    rows.push_back('{2, 1800,    0, 0, 0});
    rows.push_back('{3, 3400,  700, 0, 0});
    // Frame 3: 600 us glitch, validity window edges, 799 us glitch.
    rows.push_back('{0, 1200,  200, 0, 0});
    rows.push_back('{1, 1600,    0, 0, 0});
    rows.push_back('{2, 4400, 1000, 0, 0});
    rows.push_back('{3, 1599,  700, 0, 0});
    // Frame 4: ch3 silent, slot times out.
    rows.push_back('{0, 3000,  500, 0, 0});
    rows.push_back('{1, 3000,  500, 0, 0});
    rows.push_back('{2, 3000,  500, 0, 0});
    rows.push_back('{3,    0,    0, 1, 1});
    // Frame 5: recovery clears failsafe at frame end.
    rows.push_back('{0, 3000,  500, 0, 1});
    rows.push_back('{1, 3000,  500, 0, 1});
    rows.push_back('{2, 3000,  500, 0, 1});
    rows.push_back('{3, 3000,  500, 0, 0});

    repeat (3) @(negedge clk);
    check("rst_ratio_bus", 64'(ratio_bus), 64'd0);
    check("rst_lost", 64'(lost), 64'hf);
    check("rst_failsafe", 64'(failsafe), 64'd1);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_active_ch", 64'(active_ch), 64'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    foreach (rows[i]) begin
      wait_ch(rows[i].ch);
      sbq.push_back(rows[i]);
      if (rows[i].hi > 0) pulse(rows[i].ch, rows[i].hi);
      wait_leave(rows[i].ch);
    end
    @(negedge clk);
    check("frame_done_count", 64'(fd_count), 64'd5);
    check("lost_after_recovery", 64'(lost), 64'd0);

    // Pulse already high when ch0's slot starts: skipped; next 1700 us pulse gives 700.
    @(negedge clk);
    enable = 1'b0;
    pwm[0] = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    repeat (1000) @(negedge clk);
    pwm[0] = 1'b0;
    repeat (20) @(negedge clk);
    sbq.push_back('{0, 3400, 700, 0, 0});
    pulse(0, 3400);
    wait_leave(0);
    @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);

    // Drop enable mid-measure of a 1600 us pulse on ch1: outputs hold, no update.
    hold_bus = {13'd500, 13'd500, 13'd500, 13'd700};
    wait_ch(1);
    mon_en = 1'b0;
    pwm[1] = 1'b1;
    repeat (1000) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_active_ch", 64'(active_ch), 64'd0);
    check("dis_ratio_bus", 64'(ratio_bus), 64'(hold_bus));
    check("dis_lost", 64'(lost), 64'd0);
    check("dis_failsafe", 64'(failsafe), 64'd0);
    check("dis_frame_done", 64'(frame_done), 64'd0);
    repeat (2200) @(negedge clk);
    pwm[1] = 1'b0;
    repeat (10) @(negedge clk);
    check("dis_no_update", 64'(ratio_bus), 64'(hold_bus));
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("reen_active_ch", 64'(active_ch), 64'd0);

    // Reset mid-measure of a 1600 us pulse on ch0: outputs return to reset values at once.
    pwm[0] = 1'b1;
    repeat (1000) @(negedge clk);
    reset = 1'b1;
    #1;
    check("amid_rst_ratio_bus", 64'(ratio_bus), 64'd0);
    check("amid_rst_lost", 64'(lost), 64'hf);
    check("amid_rst_failsafe", 64'(failsafe), 64'd1);
    check("amid_rst_frame_done", 64'(frame_done), 64'd0);
    check("amid_rst_active_ch", 64'(active_ch), 64'd0);
    @(negedge clk);
    pwm[0] = 1'b0;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("final_frame_done_count", 64'(fd_count), 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
